syscall_service: RTL and testbench
==================================

# syscall_service

Synthesizable syscall service unit for the MIPS core. It sits beside the decode stage and consumes syscall events (service number in `$v0`, argument in `$a0`). Print requests are buffered in a FIFO toward a host/console drain port; exit requests halt the core once output has drained. A watchdog flags runaway programs. It replaces bench-only syscall detection with a parametrised, multi-service, back-pressured block usable in simulation and on FPGA.

## Interface
- `DATA_W`, 32, width of `v0`, `a0`, `out_data`, `exit_code`
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥2
- `WATCHDOG_CYCLES`, 100000, idle cycles in RUN before timeout; 0 disables the watchdog
- `SVC_PRINT_INT`, 1, service number: print integer
- `SVC_PRINT_CHAR`, 11, service number: print character
- `SVC_EXIT`, 10, service number: exit with code 0
- `SVC_EXIT2`, 17, service number: exit with code `a0`

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `syscall_valid`  in  1  a syscall is presented; held by the core until accepted
- `v0`  in  DATA_W  service number (register file entry 2)
- `a0`  in  DATA_W  argument (register file entry 4)
- `stall`  out  1  combinational; syscall not accepted this cycle, core must hold
- `out_valid`  out  1  FIFO head valid
- `out_kind`  out  2  0 = INT, 1 = CHAR
- `out_data`  out  DATA_W  payload; CHAR is `a0[7:0]` zero-extended
- `out_ready`  in  1  consumer accepts head
- `halted`  out  1  core must stop fetching
- `exit_code`  out  DATA_W  exit status
- `watchdog_expired`  out  1  sticky; timeout occurred
- `unknown_service`  out  1  sticky; an unrecognised `v0` was accepted
- `syscall_count`  out  32  accepted syscalls, saturating

## Operation
- States: RUN, DRAIN, HALTED, TIMEOUT. Reset → RUN.
- `stall` = (state != RUN) OR (fifo count == FIFO_DEPTH). Applies to every service, exit included.
- Accept = `syscall_valid` & !`stall`. On accept, `syscall_count` increments, saturating at 0xFFFFFFFF.
- Service handling on accept:
  - PRINT_INT pushes {INT, a0}.
  - PRINT_CHAR pushes {CHAR, a0[7:0]}.
  - EXIT sets `exit_code` = 0 and goes to DRAIN.
  - EXIT2 sets `exit_code` = a0 and goes to DRAIN.
  - Any other value sets `unknown_service` and pushes nothing.
- DRAIN → HALTED on the edge where fifo count == 0.
- RUN → TIMEOUT when the watchdog reaches WATCHDOG_CYCLES consecutive RUN cycles with no accept. The watchdog counter clears on every accept. On timeout, `exit_code` = all ones and `watchdog_expired` = 1.
- `halted` = 1 in HALTED and TIMEOUT. Both are terminal until reset.
- The FIFO keeps draining through `out_ready` in every state.
- Pop = `out_valid` & `out_ready`. Push and pop may occur in the same cycle; count is then unchanged. A full FIFO never accepts, even if a pop occurs the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: `stall` 0, `out_valid` 0, `out_kind` 0, `out_data` 0, `halted` 0, `exit_code` 0, `watchdog_expired` 0, `unknown_service` 0, `syscall_count` 0. FIFO is empty.
- Reset mid-operation flushes the FIFO and returns to RUN in the next cycle.
- Push-to-`out_valid` latency: 1 cycle when the FIFO is empty.
- `out_kind` and `out_data` are stable while `out_valid` & !`out_ready`.
- An EXIT accepted at edge N with the FIFO empty: `stall` = 1 from cycle N+1 (DRAIN), `halted` = 1 from cycle N+2.
- Timeout: `halted` and `watchdog_expired` rise in the cycle after the WATCHDOG_CYCLES-th idle cycle.
- `stall` depends combinationally on state and count only, not on `syscall_valid`.

## Test plan
- Reset, then PRINT_INT a0=42, then PRINT_CHAR a0=0x141, with `out_ready` = 1 → outputs {INT, 42} then {CHAR, 0x41}; `syscall_count` = 2; `halted` = 0.
- `out_ready` = 0 and 9 PRINT_INT requests, FIFO_DEPTH = 8 → 8 accepted, `stall` = 1 on the 9th. Raise `out_ready` → 9th accepted the cycle after the first pop; data ordered 0..8.
- 3 entries queued with `out_ready` = 0, then EXIT2 a0=7 → DRAIN with `halted` = 0. Release `out_ready` → `halted` = 1 one cycle after the FIFO empties; `exit_code` = 7.
- `v0` = 99 → `unknown_service` = 1, no FIFO push, `syscall_count` increments. Then EXIT → `exit_code` = 0 and `halted` = 1.
- WATCHDOG_CYCLES = 20 with no syscalls → `halted` and `watchdog_expired` = 1 after 20 idle cycles, `exit_code` = 0xFFFFFFFF. One accept at cycle 15 delays expiry to 20 cycles after that accept.
- Assert `reset` during DRAIN with 2 entries queued → `out_valid` = 0, state RUN, all outputs at reset values next cycle.

Source files
------------

// File: rtl/syscall_service.sv
// Syscall service unit: decodes core syscalls into buffered console output,
// exit/halt sequencing and a runaway-program watchdog.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | accepting syscalls; watchdog counting idle cycles
// ST_DRAIN   | exit requested; waiting for the output FIFO to empty
// ST_HALTED  | program exited normally; terminal until reset
// ST_TIMEOUT | watchdog expired; terminal until reset
module syscall_service #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned WATCHDOG_CYCLES = 100000,
    parameter int unsigned SVC_PRINT_INT   = 1,
    parameter int unsigned SVC_PRINT_CHAR  = 11,
    parameter int unsigned SVC_EXIT        = 10,
    parameter int unsigned SVC_EXIT2       = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syscall_valid,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              stall,
    output logic              out_valid,
    output logic [1:0]        out_kind,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted,
    output logic [DATA_W-1:0] exit_code,
    output logic              watchdog_expired,
    output logic              unknown_service,
    output logic [31:0]       syscall_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    // Down-counter reload: terminal count 0 is reached on the last idle cycle.
    localparam logic [WD_W-1:0] WD_LOAD =
        (WATCHDOG_CYCLES > 0) ? WD_W'(WATCHDOG_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] KIND_INT  = 2'd0;
    localparam logic [1:0] KIND_CHAR = 2'd1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_TIMEOUT
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] exit_code_q, exit_code_d;
    logic              unknown_q, unknown_d;
    logic [31:0]       syscall_count_q;
    logic [1:0]        kind_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

    logic is_int, is_char, is_exit, is_exit2;
    logic accept, push, pop;
    logic [1:0]        push_kind;
    logic [DATA_W-1:0] push_data;

    assign is_int   = (v0 == DATA_W'(SVC_PRINT_INT));
    assign is_char  = (v0 == DATA_W'(SVC_PRINT_CHAR));
    assign is_exit  = (v0 == DATA_W'(SVC_EXIT));
    assign is_exit2 = (v0 == DATA_W'(SVC_EXIT2));

    assign stall     = (state_q != ST_RUN) || (count_q == FULL_CNT);
    assign accept    = syscall_valid && !stall;
    assign push      = accept && (is_int || is_char);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push_kind = is_char ? KIND_CHAR : KIND_INT;
    assign push_data = is_char ? {{(DATA_W-8){1'b0}}, a0[7:0]} : a0;

    // Head is gated so the unreset storage never leaks onto the outputs.
    assign out_kind = out_valid ? kind_mem_q[rd_ptr_q] : '0;
    assign out_data = out_valid ? data_mem_q[rd_ptr_q] : '0;

    assign halted           = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
    assign watchdog_expired = (state_q == ST_TIMEOUT);
    assign exit_code        = exit_code_q;
    assign unknown_service  = unknown_q;
    assign syscall_count    = syscall_count_q;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        exit_code_d = exit_code_q;
        unknown_d   = unknown_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    wd_d = WD_LOAD;
                    if (is_exit) begin
                        exit_code_d = '0;
                        state_d     = ST_DRAIN;
                    end else if (is_exit2) begin
                        exit_code_d = a0;
                        state_d     = ST_DRAIN;
                    end else if (!is_int && !is_char) begin
                        unknown_d = 1'b1;
                    end
                end else if (WATCHDOG_CYCLES != 0) begin
                    if (wd_q == '0) begin
                        exit_code_d = '1;
                        state_d     = ST_TIMEOUT;
                    end else begin
                        wd_d = wd_q - 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) state_d = ST_HALTED;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            wd_q            <= WD_LOAD;
            exit_code_q     <= '0;
            unknown_q       <= 1'b0;
            syscall_count_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            exit_code_q <= exit_code_d;
            unknown_q   <= unknown_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept && (syscall_count_q != 32'hFFFF_FFFF))
                syscall_count_q <= syscall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            kind_mem_q[wr_ptr_q] <= push_kind;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_syscall_service.sv
// Self-checking bench for syscall_service: directed scenarios plus a random
// run scored against a queue-based model of the service rules.
module tb_syscall_service;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int WD    = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          syscall_valid;
    logic [DW-1:0] v0, a0;
    logic          stall, out_valid, out_ready, halted;
    logic [1:0]    out_kind;
    logic [DW-1:0] out_data, exit_code;
    logic          watchdog_expired, unknown_service;
    logic [31:0]   syscall_count;

    syscall_service #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WATCHDOG_CYCLES(WD),
        .SVC_PRINT_INT(1), .SVC_PRINT_CHAR(11), .SVC_EXIT(10), .SVC_EXIT2(17)
    ) dut (
        .clk(clk), .reset(reset), .syscall_valid(syscall_valid), .v0(v0), .a0(a0),
        .stall(stall), .out_valid(out_valid), .out_kind(out_kind), .out_data(out_data),
        .out_ready(out_ready), .halted(halted), .exit_code(exit_code),
        .watchdog_expired(watchdog_expired), .unknown_service(unknown_service),
        .syscall_count(syscall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
    } item_t;

    item_t       m_q[$];
    bit          m_exiting, m_halted, m_timeout, m_unknown, m_acc;
    int          m_idle;
    logic [31:0] m_count, m_exit;

    task automatic model_reset();
        m_q.delete();
        m_exiting = 0; m_halted = 0; m_timeout = 0; m_unknown = 0; m_acc = 0;
        m_idle = 0; m_count = 0; m_exit = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; syscall_valid = 1'b0; v0 = '0; a0 = '0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one cycle of inputs and advances the model across the clock edge.
    task automatic tick(input bit vld, input logic [31:0] sv, input logic [31:0] arg, input bit rdy);
        bit run, stl, pop, was_drain, was_empty;
        item_t it;
        syscall_valid = vld; v0 = sv; a0 = arg; out_ready = rdy;
        run       = !m_exiting && !m_halted;
        stl       = !run || (m_q.size() == DEPTH);
        m_acc     = vld && !stl;
        pop       = rdy && (m_q.size() != 0);
        was_drain = m_exiting && !m_halted;
        was_empty = (m_q.size() == 0);
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (m_acc) begin
            if (m_count != 32'hFFFF_FFFF) m_count++;
            m_idle = 0;
            case (sv)
                32'd1:   begin it.kind = 2'd0; it.data = arg; m_q.push_back(it); end
                32'd11:  begin it.kind = 2'd1; it.data = {24'd0, arg[7:0]}; m_q.push_back(it); end
                32'd10:  begin m_exiting = 1; m_exit = 32'd0; end
                32'd17:  begin m_exiting = 1; m_exit = arg; end
                default: m_unknown = 1;
            endcase
        end else if (run) begin
            m_idle++;
            if (m_idle == WD) begin
                m_halted = 1; m_timeout = 1; m_exit = 32'hFFFF_FFFF;
            end
        end
        if (was_drain && was_empty) m_halted = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_kind !== 2'd0) begin errors++; $display("FAIL reset_out_kind: got %0d expected 0", out_kind); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (exit_code !== 32'd0) begin errors++; $display("FAIL reset_exit_code: got %h expected 0", exit_code); end
        checks++; if (watchdog_expired !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b expected 0", watchdog_expired); end
        checks++; if (unknown_service !== 1'b0) begin errors++; $display("FAIL reset_unknown: got %b expected 0", unknown_service); end
        checks++; if (syscall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", syscall_count); end
    endtask

    task automatic test_print();
        do_reset();
        tick(1, 32'd1, 32'd42, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL print_int_valid: got %b expected 1", out_valid); end
        checks++; if (out_kind !== 2'd0) begin errors++; $display("FAIL print_int_kind: got %0d expected 0", out_kind); end
        checks++; if (out_data !== 32'd42) begin errors++; $display("FAIL print_int_data: got %0d expected 42", out_data); end
        tick(1, 32'd11, 32'h141, 1);
        checks++; if (out_kind !== 2'd1) begin errors++; $display("FAIL print_char_kind: got %0d expected 1", out_kind); end
        checks++; if (out_data !== 32'h41) begin errors++; $display("FAIL print_char_data: got %h expected 41", out_data); end
        tick(0, 32'd0, 32'd0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL print_empty: got %b expected 0", out_valid); end
        checks++; if (syscall_count !== 32'd2) begin errors++; $display("FAIL print_count: got %0d expected 2", syscall_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL print_halted: got %b expected 0", halted); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, 32'd1, i, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b expected 1", stall); end
        checks++; if (syscall_count !== 32'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", syscall_count); end
        tick(1, 32'd1, 32'd8, 0);
        checks++; if (syscall_count !== 32'd8) begin errors++; $display("FAIL full_held: got %0d expected 8", syscall_count); end
        tick(1, 32'd1, 32'd8, 1);
        checks++; if (syscall_count !== 32'd8) begin errors++; $display("FAIL full_pop_no_accept: got %0d expected 8", syscall_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_after_pop_stall: got %b expected 0", stall); end
        tick(1, 32'd1, 32'd8, 1);
        checks++; if (syscall_count !== 32'd9) begin errors++; $display("FAIL full_ninth_accept: got %0d expected 9", syscall_count); end
        for (int i = 2; i <= 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== i) begin
                errors++; $display("FAIL full_order: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, out_data, i);
            end
            tick(0, 32'd0, 32'd0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_exit_drain();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 32'd1, 100 + i, 0);
        tick(1, 32'd17, 32'd7, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b expected 1", stall); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_halted: got %b expected 0", halted); end
        checks++; if (exit_code !== 32'd7) begin errors++; $display("FAIL drain_exit_code: got %0d expected 7", exit_code); end
        tick(0, 32'd0, 32'd0, 0);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_hold: got %b expected 0", halted); end
        for (int i = 0; i < 3; i++) tick(0, 32'd0, 32'd0, 1);
        checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got valid=%b halted=%b expected 0 0", out_valid, halted);
        end
        tick(0, 32'd0, 32'd0, 1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL drain_halt: got %b expected 1", halted); end
        checks++; if (exit_code !== 32'd7) begin errors++; $display("FAIL drain_final_code: got %0d expected 7", exit_code); end
    endtask

    task automatic test_unknown();
        do_reset();
        tick(1, 32'd99, 32'd5, 1);
        checks++; if (unknown_service !== 1'b1) begin errors++; $display("FAIL unk_flag: got %b expected 1", unknown_service); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unk_no_push: got %b expected 0", out_valid); end
        checks++; if (syscall_count !== 32'd1) begin errors++; $display("FAIL unk_count: got %0d expected 1", syscall_count); end
        tick(1, 32'd10, 32'd3, 1);
        checks++; if (stall !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL exit_drain: got stall=%b halted=%b expected 1 0", stall, halted);
        end
        tick(0, 32'd0, 32'd0, 1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL exit_halt: got %b expected 1", halted); end
        checks++; if (exit_code !== 32'd0) begin errors++; $display("FAIL exit_code0: got %h expected 0", exit_code); end
        checks++; if (unknown_service !== 1'b1) begin errors++; $display("FAIL unk_sticky: got %b expected 1", unknown_service); end
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (WD - 1) tick(0, 32'd0, 32'd0, 0);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wd_early: got %b expected 0", halted); end
        tick(0, 32'd0, 32'd0, 0);
        checks++; if (halted !== 1'b1 || watchdog_expired !== 1'b1) begin
            errors++; $display("FAIL wd_expire: got halted=%b expired=%b expected 1 1", halted, watchdog_expired);
        end
        checks++; if (exit_code !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wd_code: got %h expected ffffffff", exit_code); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wd_stall: got %b expected 1", stall); end
        do_reset();
        repeat (14) tick(0, 32'd0, 32'd0, 1);
        tick(1, 32'd1, 32'd1, 1);
        repeat (WD - 1) tick(0, 32'd0, 32'd0, 1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wd_restart_early: got %b expected 0", halted); end
        tick(0, 32'd0, 32'd0, 1);
        checks++; if (watchdog_expired !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL wd_restart_expire: got halted=%b expired=%b expected 1 1", halted, watchdog_expired);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 32'd1, 32'd1, 0);
        tick(1, 32'd1, 32'd2, 0);
        tick(1, 32'd10, 32'd0, 0);
        checks++; if (stall !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got stall=%b valid=%b expected 1 1", stall, out_valid);
        end
        do_reset();
        checks++;
        if ({stall, out_valid, out_kind, out_data, halted, exit_code, watchdog_expired,
             unknown_service, syscall_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got stall=%b valid=%b kind=%0d data=%h halted=%b code=%h expired=%b unk=%b count=%0d expected all 0",
                     stall, out_valid, out_kind, out_data, halted, exit_code, watchdog_expired, unknown_service, syscall_count);
        end
        tick(1, 32'd1, 32'd5, 0);
        checks++; if (out_data !== 32'd5 || syscall_count !== 32'd1) begin
            errors++; $display("FAIL mid_run: got data=%0d count=%0d expected 5 1", out_data, syscall_count);
        end
    endtask

    task automatic test_random();
        bit          vld, rdy, pend;
        logic [31:0] sv, arg;
        int          r;
        do_reset();
        pend = 0; vld = 0; sv = 0; arg = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                vld = ($urandom_range(0, 3) != 0);
                r   = $urandom_range(0, 49);
                sv  = (r == 0) ? 32'd10 : (r == 1) ? 32'd17 : (r < 5) ? 32'd99 : (r < 27) ? 32'd1 : 32'd11;
                arg = $urandom;
            end
            rdy = $urandom_range(0, 1);
            tick(vld, sv, arg, rdy);
            pend = vld && !m_acc;
            checks++;
            if (stall !== (m_exiting || m_halted || m_q.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_stall @%0d: got %b expected %b", n, stall, (m_exiting || m_halted || m_q.size() == DEPTH));
            end
            checks++;
            if (out_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", n, out_valid, (m_q.size() != 0));
            end
            if (m_q.size() != 0) begin
                checks++;
                if (out_kind !== m_q[0].kind || out_data !== m_q[0].data) begin
                    errors++; $display("FAIL rnd_head @%0d: got kind=%0d data=%h expected kind=%0d data=%h", n, out_kind, out_data, m_q[0].kind, m_q[0].data);
                end
            end
            checks++;
            if (halted !== m_halted || watchdog_expired !== m_timeout || exit_code !== m_exit) begin
                errors++; $display("FAIL rnd_exit @%0d: got halted=%b expired=%b code=%h expected %b %b %h", n, halted, watchdog_expired, exit_code, m_halted, m_timeout, m_exit);
            end
            checks++;
            if (syscall_count !== m_count || unknown_service !== m_unknown) begin
                errors++; $display("FAIL rnd_count @%0d: got count=%0d unk=%b expected %0d %b", n, syscall_count, unknown_service, m_count, m_unknown);
            end
            if (m_halted) begin
                do_reset();
                pend = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_print();
        test_fifo_full();
        test_exit_drain();
        test_unknown();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: simulation did not finish within 2ms");
        $fatal(1, "time limit");
    end

endmodule
